split_tracked: RTL

SPLIT_TRACKED -- requirements
Module: split_tracked

---
 rtl/split_tracked_pkg.sv | 11 +
 rtl/split_err_slave.sv | 25 ++
 rtl/split_tracked.sv | 116 +++++++++++
 3 files changed

// File: rtl/split_tracked_pkg.sv
// Shared helpers for the split_tracked interconnect: select-field width and error fill pattern.
package split_tracked_pkg;

  // One select bit minimum so a single-slave build still has a valid field.
  function automatic int calc_sel_w(input int n_slaves);
    return (n_slaves <= 2) ? 1 : $clog2(n_slaves);
  endfunction

  localparam logic ERR_FILL_BIT = 1'b1;

endpackage

// File: rtl/split_err_slave.sv
// Internal decode-error responder: one registered rvalid pulse per accepted request, data all ones.
// Always ready; rvalid follows each accept by exactly one cycle.
module split_err_slave
  import split_tracked_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              accept_i,
  output logic              rvalid_o,
  output logic [DATA_W-1:0] rdata_o
);

  logic rvalid_q;

  always_ff @(posedge clk) begin
    if (rst) rvalid_q <= 1'b0;
    else     rvalid_q <= accept_i;
  end

  assign rvalid_o = rvalid_q;
  assign rdata_o  = {DATA_W{ERR_FILL_BIT}};

endmodule

// File: rtl/split_tracked.sv
// Address-decoded 1:N split with in-order response tracking; only one slave outstanding at a time.
// Optional decode-error responder for unmapped selects under SPLIT_DECERR_EN (else routed to last slave).
module split_tracked
  import split_tracked_pkg::*;
#(
  parameter int N_SLAVES = 2,
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter int MAX_OUT  = 4
) (
  input  logic                                               clk,
  input  logic                                               rst,
  input  logic                                               m_valid,
  input  logic [ADDR_W-1:0]                                  m_addr,
  input  logic [DATA_W-1:0]                                  m_wdata,
  input  logic [DATA_W/8-1:0]                                m_wstrb,
  output logic                                               m_ready,
  output logic                                               m_rvalid,
  output logic [DATA_W-1:0]                                  m_rdata,
  output logic [N_SLAVES-1:0]                                s_valid,
  output logic [N_SLAVES*(ADDR_W-calc_sel_w(N_SLAVES))-1:0]  s_addr,
  output logic [N_SLAVES*DATA_W-1:0]                         s_wdata,
  output logic [N_SLAVES*(DATA_W/8)-1:0]                     s_wstrb,
  input  logic [N_SLAVES-1:0]                                s_ready,
  input  logic [N_SLAVES-1:0]                                s_rvalid,
  input  logic [N_SLAVES*DATA_W-1:0]                         s_rdata,
  output logic [$clog2(MAX_OUT+1)-1:0]                       outstanding
);

  localparam int SEL_W  = calc_sel_w(N_SLAVES);
  localparam int SA_W   = ADDR_W - SEL_W;
  localparam int STRB_W = DATA_W / 8;
  localparam int CNT_W  = $clog2(MAX_OUT + 1);
  localparam logic [SEL_W:0]   N_EXT   = (SEL_W + 1)'(N_SLAVES);
  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_OUT);

  logic [SEL_W-1:0]  sel_raw, tgt, cur_sel_q, cur_sel_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              tgt_err, cur_err, err_rvalid;
  logic [DATA_W-1:0] err_rdata, slv_rdata;
  logic              tgt_rdy, allowed, accept, resp, slv_rvalid;

  assign sel_raw = m_addr[ADDR_W-1 -: SEL_W];

`ifdef SPLIT_DECERR_EN
  // cur_sel may hold an unmapped select; that value then means "error responder outstanding".
  assign tgt     = sel_raw;
  assign tgt_err = ({1'b0, sel_raw} >= N_EXT);
  assign cur_err = ({1'b0, cur_sel_q} >= N_EXT);

  split_err_slave #(.DATA_W(DATA_W)) u_err_slave (
    .clk      (clk),
    .rst      (rst),
    .accept_i (accept && tgt_err),
    .rvalid_o (err_rvalid),
    .rdata_o  (err_rdata)
  );
`else
  assign tgt        = ({1'b0, sel_raw} >= N_EXT) ? SEL_W'(N_SLAVES - 1) : sel_raw;
  assign tgt_err    = 1'b0;
  assign cur_err    = 1'b0;
  assign err_rvalid = 1'b0;
  assign err_rdata  = '0;
`endif

  always_comb begin
    allowed    = ((cnt_q == '0) || (tgt == cur_sel_q)) && (cnt_q < MAX_CNT);
    tgt_rdy    = tgt_err;
    slv_rvalid = 1'b0;
    slv_rdata  = '0;
    s_valid    = '0;
    s_addr     = '0;
    s_wdata    = '0;
    s_wstrb    = '0;
    for (int i = 0; i < N_SLAVES; i++) begin
      if (!tgt_err && (tgt == SEL_W'(i))) begin
        tgt_rdy                       = s_ready[i];
        s_valid[i]                    = m_valid && allowed;
        s_addr[i*SA_W +: SA_W]        = m_addr[SA_W-1:0];
        s_wdata[i*DATA_W +: DATA_W]   = m_wdata;
        s_wstrb[i*STRB_W +: STRB_W]   = m_wstrb;
      end
      if (cur_sel_q == SEL_W'(i)) begin
        slv_rvalid = s_rvalid[i];
        slv_rdata  = s_rdata[i*DATA_W +: DATA_W];
      end
    end
  end

  assign accept   = m_valid && allowed && tgt_rdy;
  assign resp     = (cnt_q != '0) && (cur_err ? err_rvalid : slv_rvalid);
  assign m_ready  = accept;
  assign m_rvalid = resp;
  assign m_rdata  = cur_err ? err_rdata : slv_rdata;

  always_comb begin
    cnt_d     = cnt_q;
    cur_sel_d = cur_sel_q;
    if (accept) cur_sel_d = tgt;
    if (accept && !resp)      cnt_d = cnt_q + 1'b1;
    else if (resp && !accept) cnt_d = cnt_q - 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q     <= '0;
      cur_sel_q <= '0;
    end else begin
      cnt_q     <= cnt_d;
      cur_sel_q <= cur_sel_d;
    end
  end

  assign outstanding = cnt_q;

endmodule
